// File: rtl/gemm_seq_ctrl_if.sv
// gemm_seq_ctrl_if: control, PE-side and operand-buffer signals of the GEMM sequencer.
interface gemm_seq_ctrl_if #(parameter int N = 16, parameter int K_W = 8);
  logic           start;
  logic           abort;
  logic [1:0]     mode;
  logic [K_W-1:0] k_len;
  logic           busy;
  logic           done;
  logic           err;
  logic [1:0]     pe_state;
  logic [1:0]     pe_flag;
  logic           sync_reset;
  logic           gemm_valid;
  logic           rd_en;
  logic [K_W-1:0] rd_addr;
  logic           drain_valid;
  logic [3:0]     drain_idx;
  modport master (
    output start, abort, mode, k_len,
    input  busy, done, err, pe_state, pe_flag, sync_reset, gemm_valid,
           rd_en, rd_addr, drain_valid, drain_idx
  );
  modport slave (
    input  start, abort, mode, k_len,
    output busy, done, err, pe_state, pe_flag, sync_reset, gemm_valid,
           rd_en, rd_addr, drain_valid, drain_idx
  );
endinterface

// File: rtl/gemm_seq_ctrl.sv
// gemm_seq_ctrl: sequences one GEMM pass (clear, feed + skew flush, drain, done) on the NxN PE grid.
// Every output is a register loaded from the next-state decode, so nothing is combinational from inputs.
module gemm_seq_ctrl #(
  parameter int N   = 16,
  parameter int K_W = 8
) (
  input logic          i_clk,
  input logic          i_rst_n,
  gemm_seq_ctrl_if.slave s
);
  localparam int CW = (K_W > 5 ? K_W : 5) + 1;
  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
  state_t         r_state, w_state;
  logic [CW-1:0]  r_cnt, w_cnt;
  logic [K_W-1:0] r_k, w_k;
  logic           w_abort, w_rej;
  logic           r_busy, r_done, r_err, r_sync, r_gemm, r_rd_en, r_dv;
  logic [K_W-1:0] r_rd_addr;
  logic [3:0]     r_didx;
  logic [1:0]     r_flag;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_k     = r_k;
    w_rej   = 1'b0;
    w_abort = s.abort && r_state != IDLE;
    case (r_state)
      IDLE: if (s.start && !s.abort) begin
        if (s.mode == 2'b00 && s.k_len != '0) begin
          w_state = CLEAR;
          w_k     = s.k_len;
        end else w_rej = 1'b1;
      end
      CLEAR: begin
        w_state = FEED;
        w_cnt   = '0;
      end
      FEED: if (r_cnt == CW'(r_k) + CW'(N - 2)) begin
        w_state = DRAIN;
        w_cnt   = '0;
      end else w_cnt = r_cnt + CW'(1);
      DRAIN: if (r_cnt == CW'(N - 1)) begin
        w_state = DONE;
        w_cnt   = '0;
      end else w_cnt = r_cnt + CW'(1);
      DONE: w_state = IDLE;
      default: w_state = IDLE;
    endcase
    if (w_abort) begin
      w_state = IDLE;
      w_cnt   = '0;
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_k       <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_sync    <= 1'b0;
      r_gemm    <= 1'b0;
      r_rd_en   <= 1'b0;
      r_rd_addr <= '0;
      r_dv      <= 1'b0;
      r_didx    <= '0;
      r_flag    <= 2'b11;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_k       <= w_k;
      r_busy    <= w_state != IDLE;
      r_done    <= w_state == DONE;
      r_err     <= w_rej;
      r_sync    <= w_state == CLEAR || w_abort;
      r_gemm    <= w_state == FEED;
      r_rd_en   <= w_state == FEED && w_cnt < CW'(w_k);
      // address advances after each read, so it rests at k_len during the skew flush
      r_rd_addr <= w_state == CLEAR ? '0 : r_rd_addr + K_W'(r_rd_en);
      r_dv      <= w_state == DRAIN;
      r_didx    <= w_state == DRAIN ? w_cnt[3:0] : 4'd0;
      r_flag    <= w_state == DONE ? 2'b00 : 2'b11;
    end
  end
  assign s.busy        = r_busy;
  assign s.done        = r_done;
  assign s.err         = r_err;
  assign s.pe_state    = 2'b00;
  assign s.pe_flag     = r_flag;
  assign s.sync_reset  = r_sync;
  assign s.gemm_valid  = r_gemm;
  assign s.rd_en       = r_rd_en;
  assign s.rd_addr     = r_rd_addr;
  assign s.drain_valid = r_dv;
  assign s.drain_idx   = r_didx;
endmodule

// File: tb/tb_gemm_seq_ctrl.sv
// tb_gemm_seq_ctrl: directed vectors and cycle-exact pass sequences for gemm_seq_ctrl.
module tb_gemm_seq_ctrl;
  localparam int N   = 16;
  localparam int K_W = 8;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int checks   = 0;
  int failures = 0;
  always #5 clk = ~clk;
  gemm_seq_ctrl_if #(.N(N), .K_W(K_W)) bus ();
  gemm_seq_ctrl #(.N(N), .K_W(K_W)) dut (.i_clk(clk), .i_rst_n(rst_n), .s(bus));
  typedef struct {
    logic start, abort;
    logic [1:0] mode;
    logic [7:0] k;
    logic busy, done, err, sync, gemm, rd, dv;
  } vec_t;
  vec_t tbl[16];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask
  task automatic chk_reset(input string t);
    chk({t, "_busy"}, bus.busy, 0);
    chk({t, "_done"}, bus.done, 0);
    chk({t, "_err"}, bus.err, 0);
    chk({t, "_sync"}, bus.sync_reset, 0);
    chk({t, "_gemm"}, bus.gemm_valid, 0);
    chk({t, "_rden"}, bus.rd_en, 0);
    chk({t, "_rdaddr"}, bus.rd_addr, 0);
    chk({t, "_dv"}, bus.drain_valid, 0);
    chk({t, "_didx"}, bus.drain_idx, 0);
    chk({t, "_pestate"}, bus.pe_state, 0);
    chk({t, "_peflag"}, bus.pe_flag, 3);
  endtask
  // expected outputs in cycle c of a pass, c counted from the start-sampling edge
  task automatic exp_cycle(input int k, input int c);
    int d;
    string t;
    d = k + 2 * N + 1;
    t = $sformatf("k%0d_c%0d", k, c);
    chk({t, "_busy"}, bus.busy, c >= 1 && c <= d);
    chk({t, "_sync"}, bus.sync_reset, c == 1);
    chk({t, "_gemm"}, bus.gemm_valid, c >= 2 && c <= k + N);
    chk({t, "_rden"}, bus.rd_en, c >= 2 && c <= k + 1);
    chk({t, "_rdaddr"}, bus.rd_addr, c < 2 ? 0 : (c <= k + 1 ? c - 2 : k));
    chk({t, "_dv"}, bus.drain_valid, c >= k + N + 1 && c <= k + 2 * N);
    chk({t, "_didx"}, bus.drain_idx, (c >= k + N + 1 && c <= k + 2 * N) ? c - (k + N + 1) : 0);
    chk({t, "_done"}, bus.done, c == d);
    chk({t, "_peflag"}, bus.pe_flag, c == d ? 0 : 3);
    chk({t, "_err"}, bus.err, 0);
    chk({t, "_pestate"}, bus.pe_state, 0);
  endtask
  task automatic run_pass(input int k, input bit hold, input int stop);
    int d;
    d = k + 2 * N + 1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.mode  = 2'b00;
    bus.k_len = K_W'(k);
    @(posedge clk);
    for (int c = 1; c <= stop; c++) begin
      @(negedge clk);
      if (!hold) bus.start = 1'b0;
      if (hold && c == d + 2) begin
        chk("hold_restart_busy", bus.busy, 1);
        chk("hold_restart_sync", bus.sync_reset, 1);
        chk("hold_restart_gemm", bus.gemm_valid, 0);
        chk("hold_restart_rdaddr", bus.rd_addr, 0);
      end else exp_cycle(k, c);
      if (c < stop) @(posedge clk);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int seen;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.mode  = 2'b00;
    bus.k_len = '0;
    tbl[0]  = '{1'b1, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 2'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 2'd1, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 2'd2, 8'd4, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 1'b0, 2'd0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 2'd0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'd0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b0, 2'd3, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 2'd0, 8'd4, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'd0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 2'd0, 8'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 2'd0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 2'd0, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 2'd1, 8'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[14] = '{1'b0, 1'b1, 2'd0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 1'b0, 2'd0, 8'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    repeat (3) @(negedge clk);
    chk_reset("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk_reset("post_reset");
    for (int i = 0; i < 16; i++) begin
      bus.start = tbl[i].start;
      bus.abort = tbl[i].abort;
      bus.mode  = tbl[i].mode;
      bus.k_len = tbl[i].k;
      @(negedge clk);
      chk($sformatf("vec%0d_busy", i), bus.busy, tbl[i].busy);
      chk($sformatf("vec%0d_done", i), bus.done, tbl[i].done);
      chk($sformatf("vec%0d_err", i), bus.err, tbl[i].err);
      chk($sformatf("vec%0d_sync", i), bus.sync_reset, tbl[i].sync);
      chk($sformatf("vec%0d_gemm", i), bus.gemm_valid, tbl[i].gemm);
      chk($sformatf("vec%0d_rden", i), bus.rd_en, tbl[i].rd);
      chk($sformatf("vec%0d_dv", i), bus.drain_valid, tbl[i].dv);
    end
    bus.start = 1'b0;
    bus.abort = 1'b0;
    run_pass(4, 1'b0, 4 + 2 * N + 2);
    run_pass(4, 1'b1, 4 + 2 * N + 3);
    bus.start = 1'b0;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("hold_abort_busy", bus.busy, 0);
    chk("hold_abort_sync", bus.sync_reset, 1);
    run_pass(8, 1'b0, 7);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("feed_abort_busy", bus.busy, 0);
    chk("feed_abort_sync", bus.sync_reset, 1);
    chk("feed_abort_gemm", bus.gemm_valid, 0);
    chk("feed_abort_rden", bus.rd_en, 0);
    chk("feed_abort_flag", bus.pe_flag, 3);
    seen = 0;
    repeat (60) begin
      @(negedge clk);
      seen = seen | int'(bus.done);
    end
    chk("feed_abort_no_done", seen, 0);
    run_pass(1, 1'b0, 1 + 2 * N + 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    chk("done_abort_done", bus.done, 0);
    chk("done_abort_sync", bus.sync_reset, 1);
    chk("done_abort_flag", bus.pe_flag, 3);
    chk("done_abort_busy", bus.busy, 0);
    run_pass(4, 1'b0, 4 + N + 1 + 5);
    rst_n = 1'b0;
    #1;
    chk_reset("async_reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_pass(4, 1'b0, 4 + 2 * N + 2);
    run_pass(255, 1'b0, 255 + 2 * N + 2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
